display_scan_engine: RTL and testbench
======================================

DISPLAY_SCAN_ENGINE -- requirements
Module: display_scan_engine

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 36, meaning highest display_number polled (1..NUM_SLOTS, max 63).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles held after setting display_number before sampling (range 1..15).
REQ-003 SHALL have parameter REFRESH_CYCLES, default 50000, meaning idle cycles between full scans (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-005 SHALL have port resetn, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port display_number, output, 6, slot currently being polled.
REQ-007 SHALL have ports display_valid (input, 1), display_name (input, 40), display_value (input, 32), slot data returned by the CPU-side display logic.
REQ-008 SHALL have ports input_valid (output, 1), input_value (output, 32), a user-entered value delivered to the CPU side.
REQ-009 SHALL have ports key_valid (input, 1) and key_code (input, 5): 0-15 hex digit, 16 ENTER, 17 CLEAR, others ignored.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_number (output, 6), out_name (output, 40), out_value (output, 32), the captured-slot stream to the LCD renderer.

Function
REQ-011 FSM states SHALL be WAIT, SET, SETTLE, CAPTURE, SEND.
REQ-012 WAIT SHALL count REFRESH_CYCLES cycles, then go to SET with slot = 1.
REQ-013 SET SHALL drive display_number = slot and go to SETTLE next cycle; display_number SHALL stay stable through SETTLE, CAPTURE and SEND.
REQ-014 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CAPTURE.
REQ-015 CAPTURE SHALL, in one cycle, register display_name/display_value/slot into out_name/out_value/out_number if display_valid=1 and go to SEND; if display_valid=0 it SHALL skip the slot without emitting.
REQ-016 SEND SHALL hold out_valid=1 with stable payload until the cycle with out_ready=1; out_valid SHALL deassert the following cycle.
REQ-017 After SEND or a skipped slot: if slot = NUM_SLOTS, go to WAIT; otherwise increment slot and go to SET.
REQ-018 out_valid SHALL never be asserted outside SEND; out_ready while out_valid=0 SHALL have no effect.
REQ-019 Hex digit key SHALL set entry <= {entry[27:0], key_code[3:0]}; digits beyond 8 shift the oldest nibble out.
REQ-020 ENTER SHALL set input_value <= entry, pulse input_valid for exactly one cycle, and clear entry to 0.
REQ-021 CLEAR SHALL set entry to 0 with no input_valid pulse; codes 18-31 SHALL be ignored.
REQ-022 The key path SHALL run independently of the scan FSM; keys arriving in any scan state SHALL be processed the same cycle.
REQ-023 input_value SHALL hold its last delivered value between ENTER events.

Reset
REQ-024 With resetn=0 at a clock edge: state=WAIT, refresh counter=0, slot=1, display_number=0, out_valid=0, out_number=0, out_name=0, out_value=0, entry=0, input_valid=0, input_value=0.
REQ-025 Reset asserted mid-scan or during SEND SHALL abandon the transaction; out_valid SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-026 Macro DISPLAY_KEY_INPUT_EN defined: key path per REQ-019..023 compiled in.
REQ-027 Macro undefined: key path absent, key_valid/key_code ignored, input_valid tied 0, input_value tied 0; scan behaviour unchanged.

Structure
REQ-028 Shared package display_pkg SHALL hold the FSM state enumeration, key code constants (KEY_ENTER=16, KEY_CLEAR=17) and the name/value/number widths (40/32/6).
REQ-029 Key-entry logic SHALL be sub-module display_key_entry; scan FSM remains in the top.

Verification
REQ-030 Reset, REFRESH_CYCLES=4, SETTLE_CYCLES=2, NUM_SLOTS=4, out_ready=1, all slots valid -> four transfers numbered 1,2,3,4 in order, then WAIT for 4 cycles, then slot 1 again.
REQ-031 Slot 3 display_valid=0 -> only slots 1,2,4 emitted; no out_valid pulse with out_number=3.
REQ-032 out_ready=0 for 10 cycles on slot 2 (name "   PC", value 0x00000010) -> out_valid held 10+ cycles, payload stable, display_number stays 2.
REQ-033 Keys 1,2,A,B,ENTER -> single-cycle input_valid, input_value=0x000012AB; then keys 9 digits 1..9,ENTER -> input_value=0x23456789.
REQ-034 Keys F,F,CLEAR,5,ENTER -> input_value=0x00000005; ENTER issued in the same cycle as a CAPTURE -> both complete correctly.
REQ-035 resetn=0 during SEND -> out_valid=0 next cycle, display_number=0, scan restarts from WAIT at slot 1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display scan engine: scan FSM states, key codes
// and the widths of the slot number, name and value fields.
package display_pkg;

  localparam int NAME_W  = 40;
  localparam int VALUE_W = 32;
  localparam int NUM_W   = 6;
  localparam int KEY_W   = 5;

  localparam logic [KEY_W-1:0] KEY_ENTER = 5'd16;
  localparam logic [KEY_W-1:0] KEY_CLEAR = 5'd17;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_SET     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4
  } scan_state_e;

endpackage

// File: rtl/display_key_entry.sv
// Hex keypad entry: digits shift into an 8-nibble entry register, ENTER
// delivers the entry as a one-cycle input_valid pulse, CLEAR empties it.
module display_key_entry
  import display_pkg::*;
(
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               key_valid_i,
  input  logic [KEY_W-1:0]   key_code_i,
  output logic               input_valid_o,
  output logic [VALUE_W-1:0] input_value_o
);

  logic [VALUE_W-1:0] entry_q, entry_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               valid_q, valid_d;

  // Decode the key presented this cycle into next entry/delivery state
  always_comb begin
    entry_d = entry_q;
    value_d = value_q;
    valid_d = 1'b0;
    if (key_valid_i) begin
      if (key_code_i[4] == 1'b0) begin
        entry_d = {entry_q[VALUE_W-5:0], key_code_i[3:0]};
      end else if (key_code_i == KEY_ENTER) begin
        value_d = entry_q;
        valid_d = 1'b1;
        entry_d = {VALUE_W{1'b0}};
      end else if (key_code_i == KEY_CLEAR) begin
        entry_d = {VALUE_W{1'b0}};
      end else begin
        entry_d = entry_q;
      end
    end else begin
      entry_d = entry_q;
    end
  end

  // Entry and delivery registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      entry_q <= {VALUE_W{1'b0}};
      value_q <= {VALUE_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign input_valid_o = valid_q;
  assign input_value_o = value_q;

endmodule

// File: rtl/display_scan_engine.sv
// Display scan engine: periodically polls slots 1..NUM_SLOTS of the CPU-side
// display logic, captures valid slots and streams them to the LCD renderer
// with a valid/ready handshake. The keypad entry path is compiled in only
// when DISPLAY_KEY_INPUT_EN is defined; otherwise input_valid/input_value
// are held at zero.
module display_scan_engine
  import display_pkg::*;
#(
  parameter int NUM_SLOTS      = 36,
  parameter int SETTLE_CYCLES  = 2,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               resetn,
  output logic [NUM_W-1:0]   display_number,
  input  logic               display_valid,
  input  logic [NAME_W-1:0]  display_name,
  input  logic [VALUE_W-1:0] display_value,
  output logic               input_valid,
  output logic [VALUE_W-1:0] input_value,
  input  logic               key_valid,
  input  logic [KEY_W-1:0]   key_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_W-1:0]   out_number,
  output logic [NAME_W-1:0]  out_name,
  output logic [VALUE_W-1:0] out_value
);

  localparam logic [31:0]      REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
  localparam logic [3:0]       SETTLE_LAST  = 4'(SETTLE_CYCLES - 1);
  localparam logic [NUM_W-1:0] LAST_SLOT    = NUM_W'(NUM_SLOTS);

  scan_state_e        state_q, state_d;
  logic [31:0]        refresh_q, refresh_d;
  logic [3:0]         settle_q, settle_d;
  logic [NUM_W-1:0]   slot_q, slot_d;
  logic [NUM_W-1:0]   disp_num_q, disp_num_d;
  logic               out_valid_q, out_valid_d;
  logic [NUM_W-1:0]   out_number_q, out_number_d;
  logic [NAME_W-1:0]  out_name_q, out_name_d;
  logic [VALUE_W-1:0] out_value_q, out_value_d;
  logic               last_slot_s;

  assign last_slot_s = (slot_q == LAST_SLOT);

  // Scan sequencing: refresh wait, slot select, settle, capture, handshake
  always_comb begin
    state_d      = state_q;
    refresh_d    = refresh_q;
    settle_d     = settle_q;
    slot_d       = slot_q;
    disp_num_d   = disp_num_q;
    out_valid_d  = out_valid_q;
    out_number_d = out_number_q;
    out_name_d   = out_name_q;
    out_value_d  = out_value_q;
    case (state_q)
      ST_WAIT: begin
        if (refresh_q == REFRESH_LAST) begin
          refresh_d = 32'd0;
          slot_d    = 6'd1;
          state_d   = ST_SET;
        end else begin
          refresh_d = refresh_q + 32'd1;
        end
      end
      ST_SET: begin
        disp_num_d = slot_q;
        settle_d   = 4'd0;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        if (display_valid) begin
          out_number_d = slot_q;
          out_name_d   = display_name;
          out_value_d  = display_value;
          out_valid_d  = 1'b1;
          state_d      = ST_SEND;
        end else begin
          // Slot has nothing to show: move on without emitting
          slot_d  = last_slot_s ? 6'd1 : slot_q + 6'd1;
          state_d = last_slot_s ? ST_WAIT : ST_SET;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          slot_d      = last_slot_s ? 6'd1 : slot_q + 6'd1;
          state_d     = last_slot_s ? ST_WAIT : ST_SET;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_WAIT;
      end
    endcase
  end

  // Scan state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_WAIT;
      refresh_q    <= 32'd0;
      settle_q     <= 4'd0;
      slot_q       <= 6'd1;
      disp_num_q   <= 6'd0;
      out_valid_q  <= 1'b0;
      out_number_q <= 6'd0;
      out_name_q   <= {NAME_W{1'b0}};
      out_value_q  <= {VALUE_W{1'b0}};
    end else begin
      state_q      <= state_d;
      refresh_q    <= refresh_d;
      settle_q     <= settle_d;
      slot_q       <= slot_d;
      disp_num_q   <= disp_num_d;
      out_valid_q  <= out_valid_d;
      out_number_q <= out_number_d;
      out_name_q   <= out_name_d;
      out_value_q  <= out_value_d;
    end
  end

  assign display_number = disp_num_q;
  assign out_valid      = out_valid_q;
  assign out_number     = out_number_q;
  assign out_name       = out_name_q;
  assign out_value      = out_value_q;

`ifdef DISPLAY_KEY_INPUT_EN
  display_key_entry u_key_entry (
    .clk_i         (clk),
    .resetn_i      (resetn),
    .key_valid_i   (key_valid),
    .key_code_i    (key_code),
    .input_valid_o (input_valid),
    .input_value_o (input_value)
  );
`else
  // Keypad path not built: key inputs are intentionally left unconsumed
  logic unused_key_s;
  assign unused_key_s = ^{key_valid, key_code};
  assign input_valid  = 1'b0;
  assign input_value  = {VALUE_W{1'b0}};
`endif

endmodule

// File: tb/tb_display_scan_engine.sv
// Randomized bench for display_scan_engine. Expected transfer timing is
// derived from the slot schedule (refresh wait, settle time, handshakes) as
// timestamp arithmetic; keypad expectations come from a nibble-shift model.
module tb_display_scan_engine;

  localparam int R = 4;
  localparam int S = 2;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic        input_valid;
  logic [31:0] input_value;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_number;
  logic [39:0] out_name;
  logic [31:0] out_value;

  always #5 clk = ~clk;

  display_scan_engine #(
    .NUM_SLOTS      (N),
    .SETTLE_CYCLES  (S),
    .REFRESH_CYCLES (R)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .display_number (display_number),
    .display_valid  (display_valid),
    .display_name   (display_name),
    .display_value  (display_value),
    .input_valid    (input_valid),
    .input_value    (input_value),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_number     (out_number),
    .out_name       (out_name),
    .out_value      (out_value)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // slot table served by the emulated CPU-side display logic
  bit          tbl_valid [1:N];
  logic [39:0] tbl_name  [1:N];
  logic [31:0] tbl_value [1:N];

  // scan model: cycle of the expected SEND start and its slot
  int cyc;
  int exp_send_t;
  int exp_slot;
  int stall_cnt;
  bit enter_at_capture;

  // key model
  bit          exp_iv;
  logic [31:0] exp_ival;
  logic [31:0] entry_m;
  int          key_q[$];
  logic [31:0] dir_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // find the next emitted slot starting with a SET at start_t for first_slot
  task automatic plan_next(input int start_t, input int first_slot);
    int  t;
    int  s;
    bit  found;
    t = start_t;
    s = first_slot;
    found = 1'b0;
    exp_send_t = 1000000;
    exp_slot = 0;
    for (int k = 0; k < 2 * N && !found; k++) begin
      if (tbl_valid[s]) begin
        exp_send_t = t + 2 + S;
        exp_slot = s;
        found = 1'b1;
      end else begin
        t = t + 2 + S;
        if (s == N) begin t = t + R; s = 1; end
        else s = s + 1;
      end
    end
  endtask

  task automatic fill_table(input int kind);
    for (int i = 1; i <= N; i++) begin
      tbl_valid[i] = (kind == 3) ? bit'($urandom_range(0, 1)) : 1'b1;
      tbl_name[i]  = {8'($urandom), $urandom};
      tbl_value[i] = $urandom;
    end
    if (kind == 1) tbl_valid[3] = 1'b0;
    if (kind == 2) begin
      tbl_name[2]  = "   PC";
      tbl_value[2] = 32'h0000_0010;
    end
    if (kind == 3) tbl_valid[N] = 1'b1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    key_valid = 1'b0;
    key_code = 5'd0;
    out_ready = 1'b0;
    display_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc = 0;
    stall_cnt = 0;
    exp_iv = 1'b0;
    exp_ival = 32'd0;
    entry_m = 32'd0;
    plan_next(R, 1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_display_number", display_number, 6'd0);
    check("rst_out_number", out_number, 6'd0);
    check("rst_out_name", out_name, 40'd0);
    check("rst_out_value", out_value, 32'd0);
    check("rst_input_value", input_value, 32'd0);
  endtask

  // check the current cycle, then drive inputs for it and advance one clock
  task automatic step(input int ready_mode, input bit do_check);
    bit ev;
    int dn;
    ev = (cyc >= exp_send_t);
    if (do_check) begin
      check("out_valid", out_valid, ev);
      if (ev) begin
        check("out_number", out_number, 6'(exp_slot));
        check("out_name", out_name, tbl_name[exp_slot]);
        check("out_value", out_value, tbl_value[exp_slot]);
        check("display_number", display_number, 6'(exp_slot));
      end
      check("input_valid", input_valid, exp_iv);
      check("input_value", input_value, exp_ival);
`ifdef DISPLAY_KEY_INPUT_EN
      if (input_valid && dir_q.size() > 0) check("dir_input_value", input_value, dir_q.pop_front());
`endif
    end
    dn = int'(display_number);
    if (dn >= 1 && dn <= N) begin
      display_valid = tbl_valid[dn];
      display_name  = tbl_name[dn];
      display_value = tbl_value[dn];
    end else begin
      display_valid = 1'b0;
      display_name  = 40'd0;
      display_value = 32'd0;
    end
    case (ready_mode)
      0: out_ready = 1'b1;
      2: begin
        if (ev && exp_slot == 2 && stall_cnt < 10) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = bit'($urandom_range(0, 1));
    endcase
    if (ev && out_ready) begin
      stall_cnt = 0;
      if (exp_slot == N) plan_next(cyc + 1 + R, 1);
      else plan_next(cyc + 1, exp_slot + 1);
    end
    key_valid = 1'b0;
    key_code = 5'd0;
    if (key_q.size() > 0) begin
      key_valid = 1'b1;
      key_code = 5'(key_q.pop_front());
    end else if (enter_at_capture && cyc == exp_send_t - 1) begin
      key_valid = 1'b1;
      key_code = 5'd16;
    end else if ($urandom_range(0, 3) == 0) begin
      key_valid = 1'b1;
      key_code = 5'($urandom_range(0, 31));
    end
    exp_iv = 1'b0;
`ifdef DISPLAY_KEY_INPUT_EN
    if (key_valid) begin
      if (key_code < 5'd16) entry_m = (entry_m << 4) | {28'd0, key_code[3:0]};
      else if (key_code == 5'd16) begin exp_iv = 1'b1; exp_ival = entry_m; entry_m = 32'd0; end
      else if (key_code == 5'd17) entry_m = 32'd0;
    end
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int guard;
    resetn = 1'b0;
    key_valid = 1'b0;
    key_code = 5'd0;
    out_ready = 1'b0;
    display_valid = 1'b0;
    display_name = 40'd0;
    display_value = 32'd0;
    enter_at_capture = 1'b0;

    // all slots valid, always ready, directed key sequences
    fill_table(0);
    do_reset();
    key_q = '{1, 2, 10, 11, 16, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 15, 15, 17, 5, 16};
    dir_q = '{32'h0000_12AB, 32'h2345_6789, 32'h0000_0005};
    for (int i = 0; i < 80; i++) step(0, 1'b1);

    // slot 3 has nothing to show, random ready, ENTER lands on CAPTURE
    fill_table(1);
    do_reset();
    enter_at_capture = 1'b1;
    for (int i = 0; i < 120; i++) step(1, 1'b1);
    enter_at_capture = 1'b0;

    // slot 2 stalled for 10 cycles, then reset while a transfer is pending
    fill_table(2);
    do_reset();
    for (int i = 0; i < 60; i++) step(2, 1'b1);
    guard = 0;
    while (cyc < exp_send_t && guard < 100) begin
      step(0, 1'b1);
      guard++;
    end
    check("send_reach", out_valid, 1'b1);

    // random slot validity and ready, starting from a reset during SEND
    fill_table(3);
    do_reset();
    for (int i = 0; i < 150; i++) step(1, 1'b1);
    do_reset();
    for (int i = 0; i < 100; i++) step(1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
